lw_hmac_key_loader: RTL and testbench

- Upstream companion of the HMAC core.
- Accepts an HMAC key of arbitrary length, up to one hash block, as a stream of words and stores it in a 16-word buffer.
- Masks the unused trailing bytes and replays the key as exactly 16 zero-padded block words on the core's key_i/key_valid_i/key_ready_o handshake, once per emit request.
- Lets one loaded key serve many HMAC operations without reloading from the host.

---
 rtl/lw_hmac_key_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_lw_hmac_key_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lw_hmac_key_loader.sv
// ---------------------------------------------------------------------------
// lw_hmac_key_loader
//
// Purpose:
//   Front end for the HMAC core's key port. A host streams in a key of up to
//   one hash block (KEY_WORDS words). The key is held in a zero-initialised
//   buffer. Bytes past the key length in the final word are masked to zero.
//   On each emit request the key is replayed as exactly KEY_WORDS
//   zero-padded words. One loaded key can therefore serve many HMAC runs.
//
// Build option:
//   HMAC_KEY_ONE_SHOT_EN
//     When defined, a completed replay wipes the key and returns to IDLE.
//     When undefined, the key stays in HELD and can be replayed again.
//
// Handshakes (both directions):
//   A word transfers on a rising edge where valid && ready are both high.
//   - The input side uses in_valid_i / in_ready_o.
//   - The output side uses key_valid_o / key_ready_i.
//   A producer keeps its data and valid stable until the transfer happens.
//
// Ports:
//   clk_i, rst_i     clock; synchronous active-high reset
//   clear_i          zeroize the key and return to IDLE (beats in/emit)
//   in_data_i        key word, big-endian (first byte in the MSBs)
//   in_valid_i       input word valid
//   in_ready_o       input word can be accepted
//   in_last_i        final key word
//   in_bytes_i       valid bytes in the final word (0..WORD_SIZE/8)
//   emit_i           replay request (pulse)
//   key_o            key word to the core
//   key_valid_o      key word valid
//   key_ready_i      core accepts the key word
//   key_loaded_o     a complete key is held
//   key_len_o        stored key length in bytes
//   busy_o           LOAD or EMIT in progress
//   err_o            sticky overflow flag
//   state_o          current FSM state (debug)
// ---------------------------------------------------------------------------
module lw_hmac_key_loader #(
    parameter int WORD_SIZE = 64,
    parameter int KEY_WORDS = 16,
    parameter int LEN_W     = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic [WORD_SIZE-1:0]              in_data_i,
    input  logic                              in_valid_i,
    input  logic                              in_last_i,
    input  logic [$clog2(WORD_SIZE/8):0]      in_bytes_i,
    output logic                              in_ready_o,
    input  logic                              emit_i,
    output logic [WORD_SIZE-1:0]              key_o,
    output logic                              key_valid_o,
    input  logic                              key_ready_i,
    output logic                              key_loaded_o,
    output logic [LEN_W-1:0]                  key_len_o,
    output logic                              busy_o,
    output logic                              err_o,
    output logic [1:0]                        state_o
);

    localparam int BYTES = WORD_SIZE / 8;
    localparam int BW    = $clog2(BYTES) + 1;
    localparam int CW    = $clog2(KEY_WORDS) + 1;
    localparam int IW    = $clog2(KEY_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HELD = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    state_t                 state_q;
    logic [WORD_SIZE-1:0]   buf_q [KEY_WORDS];
    logic [CW-1:0]          wr_cnt_q;   // words stored so far
    logic [IW-1:0]          rd_idx_q;   // word currently on key_o
    logic                   drop_q;     // overflowed: discard until in_last_i

    logic                   in_fire;
    logic [IW-1:0]          rd_next;
    logic [WORD_SIZE-1:0]   next_word;
    logic [WORD_SIZE-1:0]   first_word;

    assign state_o = state_q;
    assign in_fire = in_valid_i && in_ready_o;

    // Keep the first n bytes, counted from the MSB end, and zero the rest.
    function automatic logic [WORD_SIZE-1:0] mask_word(
        input logic [WORD_SIZE-1:0] w,
        input logic [BW-1:0]        n
    );
        logic [WORD_SIZE-1:0] r;
        r = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (b < int'(n)) begin
                r[WORD_SIZE-1-8*b -: 8] = w[WORD_SIZE-1-8*b -: 8];
            end
        end
        return r;
    endfunction

    // Words at or past the stored count read as zero. This pads the key
    // out to a full block.
    always_comb begin
        rd_next    = rd_idx_q + IW'(1);
        next_word  = '0;
        first_word = '0;
        if ({1'b0, rd_next} < wr_cnt_q) begin
            next_word = buf_q[rd_next];
        end
        if (wr_cnt_q != '0) begin
            first_word = buf_q[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            rd_idx_q     <= '0;
            drop_q       <= 1'b0;
            in_ready_o   <= 1'b1;
            key_o        <= '0;
            key_valid_o  <= 1'b0;
            key_loaded_o <= 1'b0;
            key_len_o    <= '0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
            for (int i = 0; i < KEY_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_HELD: begin
                    if (in_fire) begin
                        // A new key replaces the old one completely.
                        for (int i = 0; i < KEY_WORDS; i++) begin
                            buf_q[i] <= '0;
                        end
                        wr_cnt_q     <= CW'(1);
                        err_o        <= 1'b0;
                        drop_q       <= 1'b0;
                        key_loaded_o <= 1'b0;
                        if (in_last_i) begin
                            buf_q[0]     <= mask_word(in_data_i, in_bytes_i);
                            key_len_o    <= LEN_W'(in_bytes_i);
                            key_loaded_o <= 1'b1;
                            busy_o       <= 1'b0;
                            state_q      <= ST_HELD;
                        end else begin
                            buf_q[0]  <= in_data_i;
                            key_len_o <= '0;
                            busy_o    <= 1'b1;
                            state_q   <= ST_LOAD;
                        end
                    end else if (emit_i && state_q == ST_HELD) begin
                        rd_idx_q    <= '0;
                        key_o       <= first_word;
                        key_valid_o <= 1'b1;
                        in_ready_o  <= 1'b0;
                        busy_o      <= 1'b1;
                        state_q     <= ST_EMIT;
                    end
                end

                ST_LOAD: begin
                    if (in_fire) begin
                        if (drop_q) begin
                            if (in_last_i) begin
                                drop_q  <= 1'b0;
                                busy_o  <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end else if (wr_cnt_q == CW'(KEY_WORDS)) begin
                            // The buffer is full and the key has not ended.
                            // Flag the error and discard everything.
                            err_o        <= 1'b1;
                            key_loaded_o <= 1'b0;
                            key_len_o    <= '0;
                            wr_cnt_q     <= '0;
                            for (int i = 0; i < KEY_WORDS; i++) begin
                                buf_q[i] <= '0;
                            end
                            if (in_last_i) begin
                                busy_o  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                drop_q <= 1'b1;
                            end
                        end else begin
                            buf_q[wr_cnt_q[IW-1:0]] <= in_last_i ?
                                mask_word(in_data_i, in_bytes_i) : in_data_i;
                            wr_cnt_q <= wr_cnt_q + CW'(1);
                            if (in_last_i) begin
                                key_len_o    <= LEN_W'(wr_cnt_q) * LEN_W'(BYTES)
                                                + LEN_W'(in_bytes_i);
                                key_loaded_o <= 1'b1;
                                busy_o       <= 1'b0;
                                state_q      <= ST_HELD;
                            end
                        end
                    end
                end

                ST_EMIT: begin
                    if (key_valid_o && key_ready_i) begin
                        if (rd_idx_q == IW'(KEY_WORDS - 1)) begin
                            key_valid_o <= 1'b0;
                            key_o       <= '0;
                            in_ready_o  <= 1'b1;
                            busy_o      <= 1'b0;
                            rd_idx_q    <= '0;
`ifdef HMAC_KEY_ONE_SHOT_EN
                            // Single-use key: wipe it after one replay.
                            for (int i = 0; i < KEY_WORDS; i++) begin
                                buf_q[i] <= '0;
                            end
                            wr_cnt_q     <= '0;
                            key_loaded_o <= 1'b0;
                            key_len_o    <= '0;
                            state_q      <= ST_IDLE;
`else
                            state_q      <= ST_HELD;
`endif
                        end else begin
                            rd_idx_q <= rd_next;
                            key_o    <= next_word;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lw_hmac_key_loader.sv
module tb_lw_hmac_key_loader;

    localparam int W  = 64;
    localparam int KW = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;
    localparam logic [1:0] ST_EMIT = 2'd3;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [3:0]   in_bytes = '0;
    logic         in_ready;
    logic         emit = 1'b0;
    logic [W-1:0] key;
    logic         key_valid;
    logic         key_ready = 1'b0;
    logic         key_loaded;
    logic [7:0]   key_len;
    logic         busy;
    logic         err;
    logic [1:0]   state;

    always #5 clk = ~clk;

    lw_hmac_key_loader #(
        .WORD_SIZE (W),
        .KEY_WORDS (KW),
        .LEN_W     (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_last_i    (in_last),
        .in_bytes_i   (in_bytes),
        .in_ready_o   (in_ready),
        .emit_i       (emit),
        .key_o        (key),
        .key_valid_o  (key_valid),
        .key_ready_i  (key_ready),
        .key_loaded_o (key_loaded),
        .key_len_o    (key_len),
        .busy_o       (busy),
        .err_o        (err),
        .state_o      (state)
    );

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; outputs are then settled from that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_in_ready"}, W'(in_ready), W'(1));
        check({pfx, "_key_valid"}, W'(key_valid), W'(0));
        check({pfx, "_key"}, key, W'(0));
        check({pfx, "_loaded"}, W'(key_loaded), W'(0));
        check({pfx, "_len"}, W'(key_len), W'(0));
        check({pfx, "_busy"}, W'(busy), W'(0));
        check({pfx, "_err"}, W'(err), W'(0));
        check({pfx, "_state"}, W'(state), W'(ST_IDLE));
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic last, input logic [3:0] nb);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        in_bytes = nb;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = '0;
    endtask

    task automatic pulse_emit();
        emit = 1'b1;
        tick();
        emit = 1'b0;
    endtask

    // The 2-word test key: 11 bytes long.
    task automatic load_key_a();
        send_word(64'h0011223344556677, 1'b0, 4'd0);
        check("a_state_load", W'(state), W'(ST_LOAD));
        send_word(64'h8899AABBCCDDEEFF, 1'b1, 4'd3);
        check("a_len", W'(key_len), W'(11));
        check("a_loaded", W'(key_loaded), W'(1));
    endtask

    task automatic push_key_a();
        exp_q.push_back(64'h0011223344556677);
        exp_q.push_back(64'h8899AA0000000000);
        for (int i = 2; i < KW; i++) exp_q.push_back('0);
    endtask

    // Collect one replay against exp_q.
    // toggle=1 drives key_ready_i as 1,0,1,0,...
    task automatic collect(input bit toggle, input logic [7:0] exp_len);
        int n_xfer = 0;
        int cyc = 0;
        check("emit_valid_start", W'(key_valid), W'(1));
        check("emit_in_ready", W'(in_ready), W'(0));
        check("emit_busy", W'(busy), W'(1));
        while (key_valid && cyc < 100) begin
            key_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (key_ready) begin
                if (exp_q.size() == 0) begin
                    check("emit_extra_word", W'(1), W'(0));
                end else begin
                    check("emit_word", key, exp_q.pop_front());
                end
                n_xfer++;
            end else begin
                check("emit_hold", key, exp_q.size() > 0 ? exp_q[0] : '0);
            end
            tick();
            cyc++;
        end
        key_ready = 1'b0;
        check("emit_done_in_budget", W'(key_valid), W'(0));
        check("emit_xfers", W'(n_xfer), W'(KW));
        check("emit_cycles", W'(cyc), toggle ? W'(2 * KW - 1) : W'(KW));
        exp_q.delete();
`ifdef HMAC_KEY_ONE_SHOT_EN
        check("post_state", W'(state), W'(ST_IDLE));
        check("post_loaded", W'(key_loaded), W'(0));
        check("post_len", W'(key_len), W'(0));
`else
        check("post_state", W'(state), W'(ST_HELD));
        check("post_loaded", W'(key_loaded), W'(1));
        check("post_len", W'(key_len), W'(exp_len));
`endif
    endtask

    // Emit when no key is held: key_valid_o must stay low.
    task automatic expect_no_emit(input string tag);
        int seen = 0;
        pulse_emit();
        for (int i = 0; i < 6; i++) begin
            if (key_valid) seen++;
            tick();
        end
        check(tag, W'(seen), W'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("rst");

        // 1: 11-byte key, ready held high.
        load_key_a();
        check("t1_held", W'(state), W'(ST_HELD));
        push_key_a();
        pulse_emit();
        collect(1'b0, 8'd11);

        // 2: backpressure, then retention (or one-shot wipe).
        load_key_a();
        push_key_a();
        pulse_emit();
        collect(1'b1, 8'd11);
`ifdef HMAC_KEY_ONE_SHOT_EN
        // 7: the key was wiped, so a second emit is ignored.
        expect_no_emit("t7_second_emit");
        check("t7_loaded", W'(key_loaded), W'(0));
`else
        push_key_a();
        pulse_emit();
        collect(1'b0, 8'd11);
`endif

        // 3: 17-word overflow, last on word 17.
        for (int i = 1; i <= 16; i++) send_word(W'(i), 1'b0, 4'd0);
        check("t3_err_pre", W'(err), W'(0));
        check("t3_state_load", W'(state), W'(ST_LOAD));
        send_word(W'(17), 1'b1, 4'd8);
        check("t3_err", W'(err), W'(1));
        check("t3_loaded", W'(key_loaded), W'(0));
        check("t3_state", W'(state), W'(ST_IDLE));
        check("t3_busy", W'(busy), W'(0));
        expect_no_emit("t3_no_emit");
        check("t3_err_sticky", W'(err), W'(1));

        // 4: empty key.
        send_word({W{1'b1}}, 1'b1, 4'd0);
        check("t4_err_cleared", W'(err), W'(0));
        check("t4_len", W'(key_len), W'(0));
        check("t4_loaded", W'(key_loaded), W'(1));
        for (int i = 0; i < KW; i++) exp_q.push_back('0);
        pulse_emit();
        collect(1'b0, 8'd0);

        // 5: clear at the 5th transfer.
        send_word(64'h0102030405060708, 1'b1, 4'd8);
        check("t5_len", W'(key_len), W'(8));
        pulse_emit();
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_word", key, (i == 0) ? 64'h0102030405060708 : 64'h0);
            tick();
        end
        check("t5_valid_before_clear", W'(key_valid), W'(1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        key_ready = 1'b0;
        check("t5_valid", W'(key_valid), W'(0));
        check("t5_loaded", W'(key_loaded), W'(0));
        check("t5_len_cleared", W'(key_len), W'(0));
        check("t5_state", W'(state), W'(ST_IDLE));
        expect_no_emit("t5_no_emit");

        // 6: reset during LOAD.
        send_word(64'h1111111111111111, 1'b0, 4'd0);
        send_word(64'h2222222222222222, 1'b0, 4'd0);
        check("t6_busy_load", W'(busy), W'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("t6");
        send_word(64'hCAFEBABEDEADBEEF, 1'b1, 4'd8);
        check("t6_len", W'(key_len), W'(8));
        exp_q.push_back(64'hCAFEBABEDEADBEEF);
        for (int i = 1; i < KW; i++) exp_q.push_back('0);
        pulse_emit();
        collect(1'b0, 8'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
